dhcp_opt_parser: RTL and testbench

DHCP_OPT_PARSER -- requirements
Module: dhcp_opt_parser

---
 rtl/dhcp_opt_parser.sv | 221 ++++++++++++++++++++++
 tb/tb_dhcp_opt_parser.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dhcp_opt_parser.sv
// DHCP reply parser: consumes a UDP payload one byte per valid cycle, checks
// the BOOTP header against the expected transaction and the local hardware
// address, walks the option list and reports accept (val) or reject (err)
// one cycle after the last byte.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   din/vin    payload byte and its qualifier (op byte first)
//   eof        marks the last payload byte (only meaningful with vin)
//   exp_xid    expected transaction ID, sampled on the frame's first byte
//   val/err    one-cycle accept / reject pulses
//   msg_type, yiaddr, server_id, subnet, router, lease, dns
//              field outputs, updated together with val and held otherwise
module dhcp_opt_parser #(
    parameter logic [47:0] MAC_ADDR = 48'h0,
    parameter int          VERBOSE  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        vin,
    input  logic        eof,
    input  logic [31:0] exp_xid,
    output logic        val,
    output logic        err,
    output logic [7:0]  msg_type,
    output logic [31:0] yiaddr,
    output logic [31:0] server_id,
    output logic [31:0] subnet,
    output logic [31:0] router,
    output logic [31:0] lease,
    output logic [31:0] dns
);

    localparam logic [31:0] MAGIC = 32'h63825363;

    // Hook for simulation-only messages; carries no hardware.
    if (VERBOSE != 0) begin : g_verbose
    end

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_OPT_CODE, S_OPT_LEN, S_OPT_DATA, S_SKIP
    } state_t;

    state_t      state_q;
    logic [8:0]  ctr_q;        // index of the header byte being consumed
    logic [7:0]  code_q;       // option being walked
    logic [7:0]  len_q;        // its length
    logic [7:0]  idx_q;        // data byte index within the option
    logic [31:0] xid_q;
    logic        err_flag_q;
    logic        end_seen_q;
    logic        msg_seen_q;

    logic [7:0]  msg_type_s_q;
    logic [31:0] yiaddr_s_q, server_id_s_q, subnet_s_q, router_s_q, lease_s_q, dns_s_q;

    // Expected value of the current header byte, if that byte is checked.
    logic       chk_en_d;
    logic [7:0] chk_byte_d;

    always_comb begin
        chk_en_d   = 1'b1;
        chk_byte_d = 8'h00;
        case (ctr_q)
            9'd1:    chk_byte_d = 8'h01;
            9'd2:    chk_byte_d = 8'h06;
            9'd4:    chk_byte_d = xid_q[31:24];
            9'd5:    chk_byte_d = xid_q[23:16];
            9'd6:    chk_byte_d = xid_q[15:8];
            9'd7:    chk_byte_d = xid_q[7:0];
            9'd28:   chk_byte_d = MAC_ADDR[47:40];
            9'd29:   chk_byte_d = MAC_ADDR[39:32];
            9'd30:   chk_byte_d = MAC_ADDR[31:24];
            9'd31:   chk_byte_d = MAC_ADDR[23:16];
            9'd32:   chk_byte_d = MAC_ADDR[15:8];
            9'd33:   chk_byte_d = MAC_ADDR[7:0];
            9'd236:  chk_byte_d = MAGIC[31:24];
            9'd237:  chk_byte_d = MAGIC[23:16];
            9'd238:  chk_byte_d = MAGIC[15:8];
            9'd239:  chk_byte_d = MAGIC[7:0];
            default: chk_en_d   = 1'b0;
        endcase
    end

    logic addr_opt_d, len_bad_d, bad_now_d, end_now_d, accept_d, in_yi_d;

    assign addr_opt_d = (code_q == 8'd1) || (code_q == 8'd3) || (code_q == 8'd6) ||
                        (code_q == 8'd51) || (code_q == 8'd54);
    assign len_bad_d  = (addr_opt_d && (din < 8'd4)) || ((code_q == 8'd53) && (din == 8'd0));
    assign bad_now_d  = ((state_q == S_IDLE) && (din != 8'h02)) ||
                        ((state_q == S_HDR) && chk_en_d && (din != chk_byte_d)) ||
                        ((state_q == S_OPT_LEN) && len_bad_d);
    assign end_now_d  = (state_q == S_OPT_CODE) && (din == 8'hFF);
    // Flags are combined with this byte's own contribution so that eof on the
    // end option itself is accepted. A frame ending in IDLE/HDR is short.
    assign accept_d   = !(err_flag_q || bad_now_d) && (end_seen_q || end_now_d) && msg_seen_q &&
                        (state_q != S_IDLE) && (state_q != S_HDR);
    assign in_yi_d    = (ctr_q >= 9'd16) && (ctr_q <= 9'd19);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ctr_q         <= '0;
            code_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            xid_q         <= '0;
            err_flag_q    <= 1'b0;
            end_seen_q    <= 1'b0;
            msg_seen_q    <= 1'b0;
            msg_type_s_q  <= '0;
            yiaddr_s_q    <= '0;
            server_id_s_q <= '0;
            subnet_s_q    <= '0;
            router_s_q    <= '0;
            lease_s_q     <= '0;
            dns_s_q       <= '0;
            val           <= 1'b0;
            err           <= 1'b0;
            msg_type      <= '0;
            yiaddr        <= '0;
            server_id     <= '0;
            subnet        <= '0;
            router        <= '0;
            lease         <= '0;
            dns           <= '0;
        end else begin
            val <= 1'b0;
            err <= 1'b0;
            if (vin) begin
                case (state_q)
                    S_IDLE: begin
                        // Frame start: byte 0 is consumed here.
                        xid_q         <= exp_xid;
                        ctr_q         <= 9'd1;
                        end_seen_q    <= 1'b0;
                        msg_seen_q    <= 1'b0;
                        msg_type_s_q  <= '0;
                        yiaddr_s_q    <= '0;
                        server_id_s_q <= '0;
                        subnet_s_q    <= '0;
                        router_s_q    <= '0;
                        lease_s_q     <= '0;
                        dns_s_q       <= '0;
                        err_flag_q    <= bad_now_d;
                        state_q       <= bad_now_d ? S_SKIP : S_HDR;
                    end
                    S_HDR: begin
                        ctr_q <= ctr_q + 9'd1;
                        if (in_yi_d) yiaddr_s_q <= {yiaddr_s_q[23:0], din};
                        if (bad_now_d) begin
                            err_flag_q <= 1'b1;
                            state_q    <= S_SKIP;
                        end else if (ctr_q == 9'd239) begin
                            state_q <= S_OPT_CODE;
                        end
                    end
                    S_OPT_CODE: begin
                        if (din == 8'hFF) begin
                            end_seen_q <= 1'b1;
                            state_q    <= S_SKIP;
                        end else if (din != 8'h00) begin
                            code_q  <= din;
                            state_q <= S_OPT_LEN;
                        end
                    end
                    S_OPT_LEN: begin
                        if (len_bad_d) begin
                            err_flag_q <= 1'b1;
                            state_q    <= S_SKIP;
                        end else if (din == 8'd0) begin
                            state_q <= S_OPT_CODE;
                        end else begin
                            len_q   <= din;
                            idx_q   <= '0;
                            state_q <= S_OPT_DATA;
                        end
                    end
                    S_OPT_DATA: begin
                        if ((code_q == 8'd53) && (idx_q == 8'd0)) begin
                            msg_type_s_q <= din;
                            msg_seen_q   <= 1'b1;
                        end
                        // Address-like options keep only their first four bytes.
                        if (idx_q < 8'd4) begin
                            case (code_q)
                                8'd1:    subnet_s_q    <= {subnet_s_q[23:0], din};
                                8'd3:    router_s_q    <= {router_s_q[23:0], din};
                                8'd6:    dns_s_q       <= {dns_s_q[23:0], din};
                                8'd51:   lease_s_q     <= {lease_s_q[23:0], din};
                                8'd54:   server_id_s_q <= {server_id_s_q[23:0], din};
                                default: ;
                            endcase
                        end
                        idx_q <= idx_q + 8'd1;
                        if ((idx_q + 8'd1) == len_q) state_q <= S_OPT_CODE;
                    end
                    default: ; // S_SKIP: absorb until eof
                endcase

                if (eof) begin
                    state_q <= S_IDLE;
                    val     <= accept_d;
                    err     <= !accept_d;
                    if (accept_d) begin
                        msg_type  <= msg_type_s_q;
                        yiaddr    <= yiaddr_s_q;
                        server_id <= server_id_s_q;
                        subnet    <= subnet_s_q;
                        router    <= router_s_q;
                        lease     <= lease_s_q;
                        dns       <= dns_s_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dhcp_opt_parser.sv
module tb_dhcp_opt_parser;

    localparam logic [47:0] MAC = 48'h020000000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        vin = 1'b0;
    logic        eof = 1'b0;
    logic [31:0] exp_xid = 32'h0;
    logic        val, err;
    logic [7:0]  msg_type;
    logic [31:0] yiaddr, server_id, subnet, router, lease, dns;

    dhcp_opt_parser #(.MAC_ADDR(MAC), .VERBOSE(0)) dut (
        .clk(clk), .rst(rst), .din(din), .vin(vin), .eof(eof), .exp_xid(exp_xid),
        .val(val), .err(err), .msg_type(msg_type), .yiaddr(yiaddr),
        .server_id(server_id), .subnet(subnet), .router(router), .lease(lease), .dns(dns)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  msg;
        logic [31:0] yi, sid, sub, rt, lease, dns;
    } fields_t;

    typedef struct packed {
        bit      ok;
        int      cyc;
        fields_t f;
    } exp_t;

    exp_t       sbq[$];
    fields_t    last_acc = '0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] frame[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: decides the frame outcome from the protocol rules.
    function automatic bit parse(input logic [7:0] f[$], input logic [31:0] xid, output fields_t r);
        int n, i, l;
        logic [7:0] c;
        bit bad, endf, msgf;
        n = f.size(); r = '0; bad = 0; endf = 0; msgf = 0;
        if (n < 240) bad = 1;
        else begin
            if (f[0] != 8'h02 || f[1] != 8'h01 || f[2] != 8'h06) bad = 1;
            if ({f[4], f[5], f[6], f[7]} != xid) bad = 1;
            if ({f[28], f[29], f[30], f[31], f[32], f[33]} != MAC) bad = 1;
            if ({f[236], f[237], f[238], f[239]} != 32'h63825363) bad = 1;
            r.yi = {f[16], f[17], f[18], f[19]};
        end
        i = 240;
        while (!bad && !endf && i < n) begin
            c = f[i];
            if (c == 8'd0) i++;
            else if (c == 8'd255) endf = 1;
            else if (i + 1 >= n) i = n;
            else begin
                l = int'(f[i+1]);
                if (((c == 1 || c == 3 || c == 6 || c == 51 || c == 54) && l < 4) || (c == 53 && l == 0))
                    bad = 1;
                else begin
                    for (int k = 0; k < l && i + 2 + k < n; k++) begin
                        if (c == 53 && k == 0) begin
                            r.msg = f[i+2+k];
                            msgf = 1;
                        end else if (k < 4) begin
                            case (c)
                                1:  r.sub[31-8*k -: 8]   = f[i+2+k];
                                3:  r.rt[31-8*k -: 8]    = f[i+2+k];
                                6:  r.dns[31-8*k -: 8]   = f[i+2+k];
                                51: r.lease[31-8*k -: 8] = f[i+2+k];
                                54: r.sid[31-8*k -: 8]   = f[i+2+k];
                                default: ;
                            endcase
                        end
                    end
                    i += 2 + l;
                end
            end
        end
        return !bad && endf && msgf;
    endfunction

    // Monitor: every pulse is matched against the oldest expectation.
    exp_t me;
    always @(negedge clk) begin
        if (!rst) begin
            if (val && err) chk("val_err_together", {val, err}, 2'b10);
            if (val || err) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", {val, err}, 2'b00);
                end else begin
                    me = sbq.pop_front();
                    $display("pulse cycle=%0d val=%0b err=%0b msg=%0h yi=%0h", cyc, val, err, msg_type, yiaddr);
                    chk("pulse_cycle", cyc, me.cyc);
                    chk("val", val, me.ok);
                    chk("err", err, !me.ok);
                    chk("msg_type", msg_type, me.f.msg);
                    chk("yiaddr", yiaddr, me.f.yi);
                    chk("server_id", server_id, me.f.sid);
                    chk("subnet", subnet, me.f.sub);
                    chk("router", router, me.f.rt);
                    chk("lease", lease, me.f.lease);
                    chk("dns", dns, me.f.dns);
                end
            end
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                me = sbq.pop_front();
                chk("missing_pulse", 0, 1);
            end
        end
    end

    task automatic hdr(input logic [7:0] op, input logic [31:0] xid, input logic [47:0] mac,
                       input logic [31:0] yi, input logic [31:0] magic);
        frame.delete();
        for (int i = 0; i < 240; i++) frame.push_back(8'($urandom));
        frame[0] = op; frame[1] = 8'h01; frame[2] = 8'h06;
        for (int k = 0; k < 4; k++) begin
            frame[4+k]   = xid[31-8*k -: 8];
            frame[16+k]  = yi[31-8*k -: 8];
            frame[236+k] = magic[31-8*k -: 8];
        end
        for (int k = 0; k < 6; k++) frame[28+k] = mac[47-8*k -: 8];
    endtask

    task automatic opt(input logic [7:0] code, input int len, input logic [31:0] v);
        frame.push_back(code);
        frame.push_back(8'(len));
        for (int k = 0; k < len; k++) frame.push_back(k < 4 ? v[31-8*k -: 8] : 8'($urandom));
    endtask

    task automatic idle();
        @(negedge clk);
        vin = 1'b0; din = 8'($urandom); eof = 1'($urandom);
    endtask

    // Sends the first n bytes of frame; gap 0 none, 1 three idles every 7 bytes, 2 random.
    task automatic send(input int n, input int gap, input bit do_eof);
        logic [7:0] s[$];
        fields_t pf;
        exp_t e;
        bit ok;
        for (int i = 0; i < n; i++) s.push_back(frame[i]);
        ok = parse(s, exp_xid, pf);
        for (int i = 0; i < n; i++) begin
            if (gap == 1 && i > 0 && i % 7 == 0) repeat (3) idle();
            if (gap == 2 && $urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) idle();
            @(negedge clk);
            vin = 1'b1; din = s[i]; eof = do_eof && (i == n - 1);
            if (eof) begin
                if (ok) last_acc = pf;
                e.ok = ok; e.cyc = cyc + 1; e.f = last_acc;
                sbq.push_back(e);
                $display("frame len=%0d gap=%0d expect %s", n, gap, ok ? "val" : "err");
            end
        end
    endtask

    task automatic offer(input logic [7:0] msg, input logic [31:0] xid);
        hdr(8'h02, xid, MAC, 32'hC0A80132, 32'h63825363);
        opt(8'd53, 1, {msg, 24'h0});
        opt(8'd54, 4, 32'hC0A80101);
        opt(8'd1, 4, 32'hFFFFFF00);
        opt(8'd3, 4, 32'hC0A80101);
        opt(8'd51, 4, 32'h00015180);
        opt(8'd6, 4, 32'h08080808);
        frame.push_back(8'hFF);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_val"}, val, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_fields"}, {msg_type, yiaddr, server_id, subnet, router, lease, dns}, 0);
    endtask

    task automatic rand_frame();
        int corrupt, n, tmp, j;
        int codes[6];
        logic [31:0] xid;
        corrupt = $urandom_range(0, 12);
        xid = $urandom;
        exp_xid = xid;
        hdr(corrupt == 1 ? 8'h01 : 8'h02,
            corrupt == 2 ? xid ^ (32'h1 << $urandom_range(0, 31)) : xid,
            corrupt == 3 ? MAC ^ (48'h1 << $urandom_range(0, 47)) : MAC,
            $urandom, corrupt == 4 ? 32'h63825362 : 32'h63825363);
        if (corrupt == 5) frame[2] = 8'h07;
        codes = '{53, 54, 1, 3, 51, 6};
        for (int i = 5; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = codes[i]; codes[i] = codes[j]; codes[j] = tmp;
        end
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 3) == 0) frame.push_back(8'h00);
            if ($urandom_range(0, 3) == 0) begin
                tmp = $urandom_range(2, 250);
                if (tmp == 1 || tmp == 3 || tmp == 6 || tmp == 51 || tmp == 53 || tmp == 54) tmp = 12;
                opt(8'(tmp), $urandom_range(0, 10), $urandom);
            end
            if (codes[i] == 53) begin
                if (corrupt != 6) opt(8'd53, corrupt == 7 ? 0 : $urandom_range(1, 3), $urandom);
            end else if ($urandom_range(0, 4) != 0) begin
                opt(8'(codes[i]), corrupt == 8 ? $urandom_range(0, 3) : $urandom_range(4, 6), $urandom);
            end
        end
        if (corrupt != 9) frame.push_back(8'hFF);
        repeat ($urandom_range(0, 3)) frame.push_back(8'($urandom));
        n = frame.size();
        if (corrupt == 10) n = $urandom_range(1, frame.size());
        send(n, $urandom_range(0, 2), 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        idle();

        // Valid OFFER
        exp_xid = 32'h12345678;
        offer(8'd2, 32'h12345678);
        send(frame.size(), 0, 1'b1);
        repeat (2) idle();
        chk("offer_msg_type", msg_type, 8'd2);
        chk("offer_dns", dns, 32'h08080808);

        // Transaction ID mismatch
        offer(8'd2, 32'h12345679);
        send(frame.size(), 0, 1'b1);
        idle();

        // Truncated at byte 100, then a valid frame the next cycle
        offer(8'd2, 32'h12345678);
        send(101, 0, 1'b1);
        send(frame.size(), 0, 1'b1);
        idle();

        // Pads, unknown option 12 and a short subnet option
        hdr(8'h02, 32'h12345678, MAC, 32'h0A000001, 32'h63825363);
        frame.push_back(8'h00);
        opt(8'd53, 1, 32'h05000000);
        frame.push_back(8'h00);
        opt(8'd12, 8, $urandom);
        opt(8'd1, 2, 32'hFFFF0000);
        frame.push_back(8'hFF);
        send(frame.size(), 0, 1'b1);
        idle();

        // ACK without and with vin gaps
        offer(8'd5, 32'h12345678);
        send(frame.size(), 0, 1'b1);
        idle();
        send(frame.size(), 1, 1'b1);
        repeat (2) idle();
        chk("ack_msg_type", msg_type, 8'd5);

        // Reset in the middle of a valid frame
        offer(8'd2, 32'h12345678);
        send(150, 0, 1'b0);
        @(negedge clk);
        vin = 1'b0; eof = 1'b0; rst = 1'b1;
        #1;
        check_zero("midreset");
        last_acc = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 150; i++) void'(frame.pop_front());
        send(frame.size(), 0, 1'b1);
        offer(8'd2, 32'h12345678);
        send(frame.size(), 0, 1'b1);
        idle();

        // Randomized frames, sometimes back to back
        for (int t = 0; t < 40; t++) begin
            rand_frame();
            if ($urandom_range(0, 1) == 0) idle();
        end

        repeat (5) idle();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
